// File: rtl/num_to_str_pkg.sv
// Shared constants and state encoding for the number/string converters.
package num_to_str_pkg;

    localparam logic [7:0]  ASCII_ZERO = 8'h30;
    localparam logic [7:0]  ASCII_NL   = 8'h0A;
    localparam int unsigned MAX_DIGITS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2,
        TERM = 2'd3
    } conv_state_t;

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_ZERO + {4'h0, digit};
    endfunction

endpackage

// File: rtl/num_to_str_divmod10.sv
// Combinational divide and modulo by ten of a 32-bit unsigned value.
module divmod10 (
    input  logic [31:0] value,
    output logic [31:0] quot,
    output logic [3:0]  rem
);

    // Constant divisor lets synthesis build a dedicated reciprocal network.
    always_comb begin
        quot = value / 32'd10;
        rem  = 4'(value % 32'd10);
    end

endmodule

// File: rtl/num_to_str.sv
// Converts a 32-bit unsigned number into its decimal ASCII string,
// most significant digit first, followed by a terminator character.
module num_to_str
    import num_to_str_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR = ASCII_NL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] n_dtm,
    input  logic        n_vld,
    output logic        n_rdy,
    output logic [7:0]  s_dtm,
    output logic        s_vld,
    input  logic        s_rdy
);

    conv_state_t state;
    conv_state_t state_next;

    logic [31:0] work;
    logic [3:0]  count;
    logic [3:0]  stack [MAX_DIGITS];
    logic [31:0] quot;
    logic [3:0]  rem;
    logic [3:0]  top_idx;

    divmod10 u_divmod10 (
        .value (work),
        .quot  (quot),
        .rem   (rem)
    );

    // Digits are produced least significant first, so the top of the stack
    // holds the most significant digit once conversion finishes.
    assign top_idx = count - 4'd1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (n_vld)                state_next = CONV;
            CONV: if (quot == '0)           state_next = EMIT;
            EMIT: if (s_rdy && count == 4'd1) state_next = TERM;
            TERM: if (s_rdy)                state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // Work register, digit count and digit stack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
                stack[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (n_vld) begin
                        work  <= n_dtm;
                        count <= '0;
                    end
                end
                CONV: begin
                    stack[count] <= rem;
                    work         <= quot;
                    count        <= count + 4'd1;
                end
                EMIT: begin
                    if (s_rdy) begin
                        count <= count - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and character outputs decoded from the current state.
    always_comb begin
        n_rdy = 1'b0;
        s_vld = 1'b0;
        s_dtm = 8'h00;
        unique case (state)
            IDLE: n_rdy = 1'b1;
            CONV: ;
            EMIT: begin
                s_vld = 1'b1;
                s_dtm = digit_to_ascii(stack[top_idx]);
            end
            TERM: begin
                s_vld = 1'b1;
                s_dtm = TERM_CHAR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_num_to_str.sv
// Directed scoreboard bench for num_to_str.
module tb_num_to_str;

    logic        clk;
    logic        rst;
    logic [31:0] n_dtm;
    logic        n_vld;
    logic        n_rdy;
    logic [7:0]  s_dtm;
    logic        s_vld;
    logic        s_rdy;

    int checks;
    int errors;
    logic [7:0] exp_q [$];

    num_to_str #(.TERM_CHAR(8'h0A)) dut (
        .clk   (clk),
        .rst   (rst),
        .n_dtm (n_dtm),
        .n_vld (n_vld),
        .n_rdy (n_rdy),
        .s_dtm (s_dtm),
        .s_vld (s_vld),
        .s_rdy (s_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Queue the expected characters and present the number for one accept edge.
    task automatic send(input logic [31:0] num);
        string s;
        int    waited;
        s = $sformatf("%0d", num);
        waited = 0;
        while (n_rdy !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("n_rdy_before_send", {31'd0, n_rdy}, 32'd1);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0A);
        n_dtm = num;
        n_vld = 1'b1;
        @(posedge clk);
        #1;
        n_vld = 1'b0;
        n_dtm = 32'hDEAD_BEEF;
        chk("n_rdy_after_accept", {31'd0, n_rdy}, 32'd0);
    endtask

    // mode 0: s_rdy held high; mode 1: s_rdy pattern 1,0,0 repeating.
    task automatic drain(input int mode, input int maxpops,
                         output int lead, output int pops, output int cycles);
        logic       prev_stall;
        logic [7:0] prev_dtm;
        logic [7:0] e;
        bit         seen;
        prev_stall = 1'b0;
        prev_dtm   = 8'h00;
        seen = 0;
        lead = 0;
        pops = 0;
        cycles = 0;
        while (exp_q.size() > 0 && pops < maxpops && cycles < 300) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("vld_held_stall", {31'd0, s_vld}, 32'd1);
                chk("dtm_held_stall", {24'd0, s_dtm}, {24'd0, prev_dtm});
            end
            s_rdy = (mode == 0) ? 1'b1 : (cycles % 3 == 0);
            if (s_vld === 1'b1) seen = 1;
            if (!seen) lead++;
            if (s_vld === 1'b1 && s_rdy) begin
                e = exp_q.pop_front();
                chk("char", {24'd0, s_dtm}, {24'd0, e});
                pops++;
            end
            prev_stall = (s_vld === 1'b1) && !s_rdy;
            prev_dtm   = s_dtm;
            cycles++;
        end
        if (cycles >= 300) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    int lead, pops, cycles;

    initial begin
        checks = 0;
        errors = 0;
        rst   = 1'b1;
        n_dtm = '0;
        n_vld = 1'b0;
        s_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_vld", {31'd0, s_vld}, 32'd0);
        chk("rst_s_dtm", {24'd0, s_dtm}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_n_rdy", {31'd0, n_rdy}, 32'd1);

        // Zero
        send(32'd0);
        drain(0, 100, lead, pops, cycles);
        chk("zero_pops", pops, 2);
        chk("zero_lead", lead, 1);
        @(negedge clk);
        chk("zero_idle_n_rdy", {31'd0, n_rdy}, 32'd1);

        // 1234 with s_rdy held high: 4 conversion cycles then no gaps
        send(32'd1234);
        drain(0, 100, lead, pops, cycles);
        chk("1234_lead", lead, 4);
        chk("1234_pops", pops, 5);
        chk("1234_no_gaps", cycles, lead + pops);

        // Maximum value
        send(32'hFFFF_FFFF);
        drain(0, 100, lead, pops, cycles);
        chk("max_pops", pops, 11);
        chk("max_lead", lead, 10);

        // Stalled downstream
        send(32'd507);
        drain(1, 100, lead, pops, cycles);
        chk("507_pops", pops, 4);

        // Reset mid-emission
        send(32'd98765);
        drain(0, 2, lead, pops, cycles);
        chk("98765_partial_pops", pops, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_s_vld", {31'd0, s_vld}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_n_rdy", {31'd0, n_rdy}, 32'd1);
        chk("midrst_s_vld_after", {31'd0, s_vld}, 32'd0);
        send(32'd42);
        drain(0, 100, lead, pops, cycles);
        chk("42_pops", pops, 3);
        repeat (3) begin
            @(negedge clk);
            chk("42_quiet", {31'd0, s_vld}, 32'd0);
        end

        // Round-trip value that a string parser would produce from "100\n"
        send(32'd100);
        drain(1, 100, lead, pops, cycles);
        chk("100_pops", pops, 4);
        chk("100_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
